// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x-oversampling s_tick. It samples each bit at its midpoint and shifts data in LSB first.
// Define UART_RX_PARITY_EN to add a parity bit (even/odd per PARITY_ODD) between the data bits and the stop bit.
module uart_rx_oversampled #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
    logic            pbit_q, pbit_d;
    logic            perr_q, perr_d;
`endif

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pbit_q  <= pbit_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        pbit_d  = pbit_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(7)) begin
                        // Start bit must still be low at its midpoint, otherwise it was a glitch.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s_q, shreg_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        pbit_d  = rx_s_q;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = shreg_q;
                        ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ((^shreg_q) ^ pbit_q) != 1'(PARITY_ODD);
`endif
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    // Parity checking is compiled out; the flag stays low for any legal PARITY_ODD.
    assign parity_err   = (PARITY_ODD > 1);
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: s_tick every 4 clocks, one bit = 64 clocks.
// Build with UART_RX_PARITY_EN defined to include the parity scenarios.
module tb_uart_rx_oversampled;

`ifdef UART_RX_PARITY_EN
    localparam int PAR_CLKS = 64;
`else
    localparam int PAR_CLKS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_dout[$];
    logic       cap_ferr[$];
    logic       cap_perr[$];
    time        cap_time[$];
    int         dbl_cnt = 0;
    logic       prev_done = 1'b0;
    time        t0;

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            cap_dout.push_back(rx_dout);
            cap_ferr.push_back(frame_err);
            cap_perr.push_back(parity_err);
            cap_time.push_back($time);
            if (prev_done) dbl_cnt++;
        end
        prev_done = rx_done_tick;
    end

    task automatic clear_caps();
        cap_dout.delete();
        cap_ferr.delete();
        cap_perr.delete();
        cap_time.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        t0 = $time;
        send_bit(1'b0);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            // Low long enough to cover the stop sample, then released so the re-entered START sees a glitch.
            rx = 1'b0;
            repeat (44) @(negedge clk);
            rx = 1'b1;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulses(input int n, input string name);
        int budget = 300;
        while (cap_dout.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (cap_dout.size() !== n) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d expected %0d", name, cap_dout.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_dout, rx_done_tick, frame_err, parity_err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h done=%b ferr=%b perr=%b expected all 0",
                     rx_dout, rx_done_tick, frame_err, parity_err);
        end
        reset_n = 1'b1;
        idle(20);
    endtask

    task automatic test_single();
        clear_caps();
        send_frame(8'h55, 1'b1);
        idle(100);
        wait_pulses(1, "single");
        if (cap_dout.size() == 1) begin
            checks++;
            if (cap_dout[0] !== 8'h55) begin
                errors++;
                $display("FAIL single_dout: got %h expected 55", cap_dout[0]);
            end
            checks++;
            if (cap_ferr[0] !== 1'b0 || cap_perr[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_flags: got ferr=%b perr=%b expected 0 0", cap_ferr[0], cap_perr[0]);
            end
            checks++;
            if ((cap_time[0] - t0) / 10 < 606 + PAR_CLKS || (cap_time[0] - t0) / 10 > 613 + PAR_CLKS) begin
                errors++;
                $display("FAIL single_latency: got %0d clks expected %0d..%0d",
                         (cap_time[0] - t0) / 10, 606 + PAR_CLKS, 613 + PAR_CLKS);
            end
        end
        checks++;
        if (rx_dout !== 8'h55) begin
            errors++;
            $display("FAIL single_hold: got %h expected 55", rx_dout);
        end
    endtask

    task automatic test_back_to_back();
        clear_caps();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(100);
        wait_pulses(2, "b2b");
        if (cap_dout.size() == 2) begin
            checks++;
            if (cap_dout[0] !== 8'hA3 || cap_dout[1] !== 8'h0F) begin
                errors++;
                $display("FAIL b2b_dout: got %h %h expected a3 0f", cap_dout[0], cap_dout[1]);
            end
            checks++;
            if (cap_ferr[0] !== 1'b0 || cap_ferr[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ferr: got %b %b expected 0 0", cap_ferr[0], cap_ferr[1]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_caps();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        checks++;
        if (cap_dout.size() !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d expected 0", cap_dout.size());
        end
        checks++;
        if (rx_dout !== 8'h0F) begin
            errors++;
            $display("FAIL glitch_hold: got %h expected 0f", rx_dout);
        end
    endtask

    task automatic test_frame_err();
        clear_caps();
        send_frame(8'hFF, 1'b0);
        idle(200);
        wait_pulses(1, "ferr");
        if (cap_dout.size() == 1) begin
            checks++;
            if (cap_dout[0] !== 8'hFF || cap_ferr[0] !== 1'b1) begin
                errors++;
                $display("FAIL ferr_frame: got dout=%h ferr=%b expected ff 1", cap_dout[0], cap_ferr[0]);
            end
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_hold: got %b expected 1", frame_err);
        end
        send_frame(8'h12, 1'b1);
        idle(100);
        wait_pulses(2, "ferr_next");
        if (cap_dout.size() == 2) begin
            checks++;
            if (cap_dout[1] !== 8'h12 || cap_ferr[1] !== 1'b0) begin
                errors++;
                $display("FAIL ferr_recover: got dout=%h ferr=%b expected 12 0", cap_dout[1], cap_ferr[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h3C;
        clear_caps();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_dout, rx_done_tick, frame_err, parity_err} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got dout=%h done=%b ferr=%b perr=%b expected all 0",
                     rx_dout, rx_done_tick, frame_err, parity_err);
        end
        reset_n = 1'b1;
        idle(400);
        checks++;
        if (cap_dout.size() !== 0) begin
            errors++;
            $display("FAIL midreset_pulses: got %0d expected 0", cap_dout.size());
        end
        send_frame(8'h3C, 1'b1);
        idle(100);
        wait_pulses(1, "midreset_next");
        if (cap_dout.size() == 1) begin
            checks++;
            if (cap_dout[0] !== 8'h3C || cap_ferr[0] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_frame: got dout=%h ferr=%b expected 3c 0", cap_dout[0], cap_ferr[0]);
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_caps();
        send_bit(1'b0);
        send_data(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_data(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(100);
        wait_pulses(2, "parity");
        if (cap_dout.size() == 2) begin
            checks++;
            if (cap_dout[0] !== 8'h07 || cap_perr[0] !== 1'b0) begin
                errors++;
                $display("FAIL parity_good: got dout=%h perr=%b expected 07 0", cap_dout[0], cap_perr[0]);
            end
            checks++;
            if (cap_dout[1] !== 8'h07 || cap_perr[1] !== 1'b1) begin
                errors++;
                $display("FAIL parity_bad: got dout=%h perr=%b expected 07 1", cap_dout[1], cap_perr[1]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (dbl_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_width: got %0d consecutive-cycle pulses expected 0", dbl_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
